// File: rtl/tdm_demux_1to4.sv
// Receive end of a 4:1 TDM link: steers one serial bit per accepted cycle into lanes 0..3 and emits the 4-bit word.
// Latency 1 cycle from the lane-3 bit to data_out/out_valid; no backpressure, in_valid low simply stretches the frame.
module tdm_demux_1to4 #(
    parameter bit RESYNC_ON_START = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    input  logic       in_valid,
    input  logic       frame_start,
    output logic [3:0] data_out,
    output logic       out_valid,
    output logic [3:0] lane_strobe,
    output logic [1:0] slot,
    output logic       sync_err
);

    logic [1:0] slot_q, slot_d;
    logic [2:0] shadow_q, shadow_d;
    logic [3:0] data_q, data_d;
    logic       out_valid_q, out_valid_d;
    logic [3:0] strobe_q, strobe_d;
    logic       sync_err_q, sync_err_d;
    logic [1:0] lane;

    always_comb begin
        slot_d      = slot_q;
        shadow_d    = shadow_q;
        data_d      = data_q;
        out_valid_d = 1'b0;
        strobe_d    = 4'b0000;
        sync_err_d  = 1'b0;
        lane        = slot_q;

        if (in_valid) begin
            // A frame_start only realigns when resync is enabled; it is always checked.
            if (RESYNC_ON_START && frame_start) begin
                lane = 2'd0;
            end
            sync_err_d = frame_start && (slot_q != 2'd0);

            if (lane == 2'd3) begin
                data_d      = {serial_in, shadow_q};
                out_valid_d = 1'b1;
            end else begin
                shadow_d[lane] = serial_in;
            end

            slot_d   = lane + 2'd1;
            strobe_d = 4'b0001 << lane;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q      <= 2'd0;
            shadow_q    <= 3'b000;
            data_q      <= 4'b0000;
            out_valid_q <= 1'b0;
            strobe_q    <= 4'b0000;
            sync_err_q  <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            shadow_q    <= shadow_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            strobe_q    <= strobe_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign data_out    = data_q;
    assign out_valid   = out_valid_q;
    assign lane_strobe = strobe_q;
    assign slot        = slot_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Bench for tdm_demux_1to4: resync and no-resync instances share stimulus; words are scoreboarded.
module tb_tdm_demux_1to4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial_in = 1'b0;
    logic       in_valid = 1'b0;
    logic       frame_start = 1'b0;

    logic [3:0] data_out, data_out_nr;
    logic       out_valid, out_valid_nr;
    logic [3:0] lane_strobe, lane_strobe_nr;
    logic [1:0] slot, slot_nr;
    logic       sync_err, sync_err_nr;

    int n_chk  = 0;
    int n_pass = 0;
    int ov_cnt = 0;
    logic [3:0] sb[$];

    always #5 clk = ~clk;

    tdm_demux_1to4 #(.RESYNC_ON_START(1'b1)) dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .in_valid(in_valid),
        .frame_start(frame_start), .data_out(data_out), .out_valid(out_valid),
        .lane_strobe(lane_strobe), .slot(slot), .sync_err(sync_err)
    );

    tdm_demux_1to4 #(.RESYNC_ON_START(1'b0)) dut_nr (
        .clk(clk), .rst(rst), .serial_in(serial_in), .in_valid(in_valid),
        .frame_start(frame_start), .data_out(data_out_nr), .out_valid(out_valid_nr),
        .lane_strobe(lane_strobe_nr), .slot(slot_nr), .sync_err(sync_err_nr)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    // Word scoreboard: every out_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            ov_cnt++;
            if (sb.size() == 0) chk("spurious_word", {28'd0, data_out}, 32'hFFFF_FFFF);
            else chk("word", {28'd0, data_out}, {28'd0, sb.pop_front()});
        end
    end

    task automatic send_bit(input logic b, input logic fs);
        serial_in   = b;
        frame_start = fs;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid    = 1'b0;
        frame_start = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [3:0] w, input logic fs);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) sb.push_back(w);
            send_bit(w[i], fs && (i == 0));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"}, {28'd0, data_out}, 0);
        chk({tag, "_ov"}, {31'd0, out_valid}, 0);
        chk({tag, "_strobe"}, {28'd0, lane_strobe}, 0);
        chk({tag, "_slot"}, {30'd0, slot}, 0);
        chk({tag, "_err"}, {31'd0, sync_err}, 0);
        chk({tag, "_slot_nr"}, {30'd0, slot_nr}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int ov_before;
        #1;
        chk_all_zero("rst_init");
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-frame after two bits.
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        chk("pre_rst_slot", {30'd0, slot}, 2);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;

        ov_before = ov_cnt;
        send_word(4'b1101, 1'b1);
        chk("first_ov", {31'd0, out_valid}, 1);
        chk("first_data", {28'd0, data_out}, 4'hD);
        idle(1);
        chk("first_ov_drop", {31'd0, out_valid}, 0);
        chk("first_pulses", ov_cnt - ov_before, 1);

        // Back-to-back words: strobe rotates, out_valid only on the lane-3 cycle.
        begin
            logic [3:0] words [3];
            words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'hF;
            for (int w = 0; w < 3; w++) begin
                for (int i = 0; i < 4; i++) begin
                    if (i == 3) sb.push_back(words[w]);
                    send_bit(words[w][i], i == 0);
                    chk("cont_strobe", {28'd0, lane_strobe}, 32'd1 << i);
                    chk("cont_ov", {31'd0, out_valid}, (i == 3) ? 1 : 0);
                end
            end
        end

        // Gapped word 6.
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        for (int g = 0; g < 3; g++) begin
            idle(1);
            chk("gap_slot", {30'd0, slot}, 2);
            chk("gap_data", {28'd0, data_out}, 4'hF);
            chk("gap_strobe", {28'd0, lane_strobe}, 0);
        end
        send_bit(1'b1, 1'b0);
        chk("gap_hold_data", {28'd0, data_out}, 4'hF);
        sb.push_back(4'h6);
        send_bit(1'b0, 1'b0);
        chk("gap_ov", {31'd0, out_valid}, 1);
        idle(1);

        // Garbage then frame_start: resync instance realigns, other only flags.
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("garbage_slot", {30'd0, slot}, 2);
        send_bit(1'b1, 1'b1);
        chk("resync_err", {31'd0, sync_err}, 1);
        chk("resync_slot", {30'd0, slot}, 1);
        chk("nr_err", {31'd0, sync_err_nr}, 1);
        chk("nr_slot", {30'd0, slot_nr}, 3);
        send_bit(1'b0, 1'b0);
        chk("resync_err_drop", {31'd0, sync_err}, 0);
        send_bit(1'b0, 1'b0);
        sb.push_back(4'h9);
        send_bit(1'b1, 1'b0);
        chk("resync_ov", {31'd0, out_valid}, 1);
        idle(2);

        // Realign both instances, then frame_start at slot 0 is clean.
        rst = 1'b1;
        #1 rst = 1'b0;
        send_bit(1'b1, 1'b1);
        chk("fs_slot0_err", {31'd0, sync_err}, 0);
        chk("fs_slot0_err_nr", {31'd0, sync_err_nr}, 0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        sb.push_back(4'h3);
        send_bit(1'b0, 1'b0);
        chk("idle_word_ov", {31'd0, out_valid}, 1);

        for (int c = 0; c < 10; c++) begin
            idle(1);
            chk("idle_data", {28'd0, data_out}, 4'h3);
            chk("idle_ov", {31'd0, out_valid}, 0);
            chk("idle_strobe", {28'd0, lane_strobe}, 0);
            chk("idle_err", {31'd0, sync_err}, 0);
            chk("idle_slot", {30'd0, slot}, 0);
        end

        chk("sb_empty", sb.size(), 0);
        chk("word_count", ov_cnt, 7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
